// File: rtl/uart_led_ctrl.sv
// rtl/uart_led_ctrl.sv - UART command parser driving RGB LED mask, PWM brightness and blink.
// Optional RGB_ACTIVE_LOW_EN inverts the rgb port for an open-drain LED driver.
module uart_led_ctrl #(
  parameter int TIMEOUT_CYCLES    = 1200000,
  parameter int BLINK_UNIT_CYCLES = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rxbyte,
  input  logic       received,
  output logic [2:0] rgb,
  output logic       busy,
  output logic       cmd_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_UNIT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BU_LAST = BW'(BLINK_UNIT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT_ARG} state_t;

  state_t        r_state;
  logic [7:0]    r_opcode;
  logic [2:0]    r_mask;
  logic [7:0]    r_duty;
  logic [7:0]    r_period;
  logic [TW-1:0] r_to_cnt;
  logic [BW-1:0] r_unit_cnt;
  logic [7:0]    r_unit_num;
  logic          r_phase;
  logic          r_busy;
  logic          r_cmd_err;
  logic [7:0]    r_pwm_cnt;
  logic [2:0]    r_rgb;
  logic          w_pwm_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_opcode   <= 8'h00;
      r_mask     <= 3'b000;
      r_duty     <= 8'hFF;
      r_period   <= 8'h00;
      r_to_cnt   <= '0;
      r_unit_cnt <= '0;
      r_unit_num <= 8'h00;
      r_phase    <= 1'b1;
      r_busy     <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;

      // Blink phase; an 'F' argument below overrides this on the same edge.
      if (r_period == 8'h00) begin
        r_unit_cnt <= '0;
        r_unit_num <= 8'h00;
        r_phase    <= 1'b1;
      end else if (r_unit_cnt == BU_LAST) begin
        r_unit_cnt <= '0;
        if (r_unit_num == r_period - 8'd1) begin
          r_unit_num <= 8'h00;
          r_phase    <= ~r_phase;
        end else begin
          r_unit_num <= r_unit_num + 8'd1;
        end
      end else begin
        r_unit_cnt <= r_unit_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (received) begin
            case (rxbyte)
              8'h4E: begin
                case (r_mask)
                  3'b000:  r_mask <= 3'b001;
                  3'b001:  r_mask <= 3'b011;
                  3'b011:  r_mask <= 3'b111;
                  default: r_mask <= 3'b000;
                endcase
              end
              8'h53, 8'h42, 8'h46: begin
                r_opcode <= rxbyte;
                r_state  <= S_WAIT_ARG;
                r_busy   <= 1'b1;
                r_to_cnt <= '0;
              end
              8'h0D, 8'h0A: ;
              default: r_cmd_err <= 1'b1;
            endcase
          end
        end
        S_WAIT_ARG: begin
          // A byte arriving on the timeout cycle still counts as the argument.
          if (received) begin
            case (r_opcode)
              8'h53: r_mask <= rxbyte[2:0];
              8'h42: r_duty <= rxbyte;
              8'h46: begin
                r_period   <= rxbyte;
                r_unit_cnt <= '0;
                r_unit_num <= 8'h00;
                r_phase    <= 1'b1;
              end
              default: ;
            endcase
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_to_cnt == TO_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cmd_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pwm_on = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= 8'h00;
      r_rgb     <= 3'b000;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_rgb     <= r_mask & {3{w_pwm_on & r_phase}};
    end
  end

`ifdef RGB_ACTIVE_LOW_EN
  assign rgb = ~r_rgb;
`else
  assign rgb = r_rgb;
`endif
  assign busy    = r_busy;
  assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_uart_led_ctrl.sv
// tb/tb_uart_led_ctrl.sv - directed self-checking bench for uart_led_ctrl.
// Timeout and blink unit shortened to 50 and 10 cycles.
module tb_uart_led_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rxbyte;
  logic       received;
  logic [2:0] rgb;
  logic       busy;
  logic       cmd_err;
  logic [2:0] w_rgb;

  int tests;
  int fails;

  uart_led_ctrl #(
    .TIMEOUT_CYCLES   (50),
    .BLINK_UNIT_CYCLES(10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rxbyte  (rxbyte),
    .received(received),
    .rgb     (rgb),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

`ifdef RGB_ACTIVE_LOW_EN
  assign w_rgb = ~rgb;
`else
  assign w_rgb = rgb;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling posedge.
  task automatic send_byte(input logic [7:0] b);
    rxbyte   = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    rxbyte   = 8'h00;
  endtask

  initial begin
    int bad;
    int c0, c1, c2;
    int bcount, errs;
    logic [2:0] exp_rgb;
    logic [2:0] prev;
    logic [2:0] step_exp [4];

    tests = 0;
    fails = 0;
    rst = 1'b1;
    received = 1'b0;
    rxbyte = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_rgb", 32'(w_rgb), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_err", 32'(cmd_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    step_exp[0] = 3'b001;
    step_exp[1] = 3'b011;
    step_exp[2] = 3'b111;
    step_exp[3] = 3'b000;
    prev = 3'b000;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h4E);
      check("N_latency_old", 32'(w_rgb), 32'(prev));
      @(negedge clk);
      check("N_step", 32'(w_rgb), 32'(step_exp[i]));
      prev = step_exp[i];
    end

    send_byte(8'h53);
    check("S_busy", 32'(busy), 32'h1);
    send_byte(8'hFD);
    check("S_busy_clr", 32'(busy), 32'h0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (w_rgb !== 3'b101) bad++;
      @(negedge clk);
    end
    check("S_static_101", 32'(bad), 32'h0);

    send_byte(8'h42);
    send_byte(8'h40);
    @(negedge clk);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 256; i++) begin
      if (w_rgb[0]) c0++;
      if (w_rgb[1]) c1++;
      if (w_rgb[2]) c2++;
      @(negedge clk);
    end
    check("pwm_r_64", 32'(c0), 32'd64);
    check("pwm_g_0", 32'(c1), 32'd0);
    check("pwm_b_64", 32'(c2), 32'd64);

    send_byte(8'h42);
    send_byte(8'h00);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (w_rgb !== 3'b000) bad++;
      @(negedge clk);
    end
    check("duty0_off", 32'(bad), 32'h0);

    send_byte(8'h42);
    send_byte(8'hFF);
    send_byte(8'h46);
    send_byte(8'h02);
    bad = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      exp_rgb = (((k - 1) / 20) % 2 == 0) ? 3'b101 : 3'b000;
      if (w_rgb !== exp_rgb) bad++;
    end
    check("blink_20", 32'(bad), 32'h0);
    send_byte(8'h46);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    check("blink_off", 32'(w_rgb), 32'h5);

    send_byte(8'h53);
    bcount = 0;
    errs = 0;
    for (int k = 0; k <= 60; k++) begin
      if (busy) bcount++;
      if (cmd_err) errs++;
      @(negedge clk);
    end
    check("timeout_busy_len", 32'(bcount), 32'd50);
    check("timeout_err_pulses", 32'(errs), 32'd1);
    check("timeout_mask_kept", 32'(w_rgb), 32'h5);

    send_byte(8'h53);
    repeat (49) @(negedge clk);
    check("arg49_still_busy", 32'(busy), 32'h1);
    send_byte(8'h02);
    check("arg49_busy_clr", 32'(busy), 32'h0);
    check("arg49_no_err", 32'(cmd_err), 32'h0);
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cmd_err) errs++;
    end
    check("arg49_no_err_later", 32'(errs), 32'h0);
    check("arg49_applied", 32'(w_rgb), 32'h2);

    send_byte(8'h78);
    check("bad_byte_err", 32'(cmd_err), 32'h1);
    @(negedge clk);
    check("bad_byte_pulse_one", 32'(cmd_err), 32'h0);
    check("bad_byte_rgb", 32'(w_rgb), 32'h2);
    check("bad_byte_busy", 32'(busy), 32'h0);
    send_byte(8'h0D);
    check("cr_no_err", 32'(cmd_err), 32'h0);
    send_byte(8'h0A);
    check("lf_no_err", 32'(cmd_err), 32'h0);

    send_byte(8'h53);
    check("rst_mid_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_rgb", 32'(w_rgb), 32'h0);
    rst = 1'b0;
    send_byte(8'h07);
    check("post_rst_opcode_err", 32'(cmd_err), 32'h1);
    check("post_rst_not_busy", 32'(busy), 32'h0);
    @(negedge clk);
    check("post_rst_mask", 32'(w_rgb), 32'h0);

    rst = 1'b1;
    send_byte(8'h53);
    rst = 1'b0;
    @(negedge clk);
    check("rx_during_rst_ignored", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
